// File: rtl/if_fetch_if.sv
// Instruction-bus port of the fetch stage.
// Pipelined request/grant address phase with in-order response data.
interface if_fetch_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rvalid,
      output rdata
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: credit-limited sequential fetch into a small in-order {pc, inst} queue,
// with branch redirect that flushes the queue and drops responses still in flight.
module if_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_branch_flag_i,
   input  logic [31:0] ex_branch_addr_i,
   input  logic [4:0]  stalled_i,
   if_fetch_if.master  ibus,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   // Stale responses accumulate across repeated redirects, so this counter is wider than the queue.
   localparam int DISC_W = 8;
   localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

   generate
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("if_fetch: FIFO_DEPTH must be a power of two and at least 2");
      end
   endgenerate

   logic [31:0]       fetch_pc_reg, fetch_pc_next;
   logic [31:0]       rsp_pc_reg, rsp_pc_next;
   logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
   logic [DISC_W-1:0] discard_reg, discard_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;

   logic [31:0] pc_mem   [FIFO_DEPTH];
   logic [31:0] inst_mem [FIFO_DEPTH];

   logic        branch;
   logic [31:0] target;
   logic [CNT_W:0] credit_used;
   logic        credit_ok;
   logic        fire;
   logic        rsp_live;
   logic        rsp_stale;
   logic        push;
   logic        pop;
   logic        unused_inputs;

   assign branch      = ex_branch_flag_i;
   assign target      = {ex_branch_addr_i[31:2], 2'b00};
   assign credit_used = {1'b0, count_reg} + {1'b0, outstanding_reg};
   // Queue entries plus live requests never exceed the depth; this cycle's pop earns no credit.
   assign credit_ok   = credit_used < CREDIT_MAX;

   assign ibus.req  = rst & credit_ok & ~branch;
   assign ibus.addr = fetch_pc_reg;

   assign fire      = ibus.req & ibus.gnt;
   assign rsp_stale = ibus.rvalid & (discard_reg != '0);
   assign rsp_live  = ibus.rvalid & (discard_reg == '0);
   assign push      = rsp_live & ~branch;
   assign pop       = (count_reg != '0) & ~stalled_i[1] & ~branch;

   assign unused_inputs = ^{stalled_i[4:2], stalled_i[0], ex_branch_addr_i[1:0]};

   always_comb begin
      fetch_pc_next    = fetch_pc_reg;
      rsp_pc_next      = rsp_pc_reg;
      outstanding_next = outstanding_reg;
      discard_next     = discard_reg;
      count_next       = count_reg;
      rd_ptr_next      = rd_ptr_reg;
      wr_ptr_next      = wr_ptr_reg;

      if (branch) begin
         // Every live request becomes stale; a response landing this cycle is consumed here.
         fetch_pc_next    = target;
         rsp_pc_next      = target;
         outstanding_next = '0;
         discard_next     = discard_reg + DISC_W'(outstanding_reg) - DISC_W'(ibus.rvalid);
         count_next       = '0;
         rd_ptr_next      = '0;
         wr_ptr_next      = '0;
      end else begin
         if (fire) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
         end
         if (push) begin
            rsp_pc_next = rsp_pc_reg + 32'd4;
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
         end
         if (rsp_stale) begin
            discard_next = discard_reg - DISC_W'(1);
         end

         case ({fire, rsp_live})
            2'b10:   outstanding_next = outstanding_reg + CNT_W'(1);
            2'b01:   outstanding_next = outstanding_reg - CNT_W'(1);
            default: outstanding_next = outstanding_reg;
         endcase

         case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_reg    <= RESET_PC;
         rsp_pc_reg      <= RESET_PC;
         outstanding_reg <= '0;
         discard_reg     <= '0;
         count_reg       <= '0;
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
      end else begin
         fetch_pc_reg    <= fetch_pc_next;
         rsp_pc_reg      <= rsp_pc_next;
         outstanding_reg <= outstanding_next;
         discard_reg     <= discard_next;
         count_reg       <= count_next;
         rd_ptr_reg      <= rd_ptr_next;
         wr_ptr_reg      <= wr_ptr_next;
      end
   end

   // Payload storage needs no reset: the head is only exposed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
         inst_mem[wr_ptr_reg] <= ibus.rdata;
      end
   end

   assign pc_o   = (count_reg != '0) ? pc_mem[rd_ptr_reg]   : 32'h0000_0000;
   assign inst_o = (count_reg != '0) ? inst_mem[rd_ptr_reg] : 32'h0000_0000;
endmodule
